// File: rtl/popcount_binarize_pack.sv
// popcount_binarize_pack
//   Output end of the XNOR-popcount datapath. Sums CHUNKS chunk popcounts into
//   one neuron sum, binarizes it against a per-neuron threshold (sum >= thr),
//   and packs successive neuron bits LSB-first into PACK_W-bit words for the
//   next layer. A flush request emits a partially filled word after the
//   current neuron completes.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   in_cnt/thr valid
//   in_ready   block accepts a beat this cycle (~out_valid | out_ready)
//   in_cnt     chunk popcount, unsigned, CNT_W bits
//   thr        neuron threshold, unsigned, ACC_W bits, taken on first beat
//   flush      single-cycle request to emit the partial word
//   out_valid  out_data/out_nbits valid
//   out_ready  downstream accepts the word
//   out_data   packed neuron bits, bit k = k-th neuron, unused MSBs zero
//   out_nbits  number of valid bits in out_data
module popcount_binarize_pack #(
    parameter  int CNT_W  = 9,
    parameter  int CHUNKS = 4,
    parameter  int PACK_W = 256,
    localparam int ACC_W  = CNT_W + $clog2(CHUNKS),
    localparam int NB_W   = $clog2(PACK_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic [ACC_W-1:0]  thr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] out_data,
    output logic [NB_W-1:0]   out_nbits
);

    localparam int CI_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int BI_W = $clog2(PACK_W);
    localparam logic [CI_W-1:0] LAST_CHUNK = CI_W'(CHUNKS - 1);
    localparam logic [BI_W-1:0] LAST_BIT   = BI_W'(PACK_W - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  thr_q;
    logic [CI_W-1:0]   chunk_idx;
    logic [BI_W-1:0]   bit_idx;
    logic [PACK_W-1:0] shift;
    logic              flush_pend;

    logic              beat_hs;
    logic              first_beat;
    logic              last_beat;
    logic              neuron_done;
    logic              word_full;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  cmp_thr;
    logic              neuron_bit;
    logic              flush_idle;
    logic              flush_emit;
    logic              flush_drop;
    logic [PACK_W-1:0] shift_ins;

    // Unsigned threshold decision for one neuron.
    function automatic logic binarize(input logic [ACC_W-1:0] s,
                                      input logic [ACC_W-1:0] t);
        return (s >= t);
    endfunction

    // Stage 0: accumulate and binarize (combinational view of the current beat)
    assign in_ready    = ~out_valid | out_ready;
    assign beat_hs     = in_valid & in_ready;
    assign first_beat  = (chunk_idx == '0);
    assign last_beat   = (chunk_idx == LAST_CHUNK);
    assign neuron_done = beat_hs & last_beat;
    assign word_full   = neuron_done & (bit_idx == LAST_BIT);

    // On the first beat the old acc is ignored, so a one-beat neuron
    // (CHUNKS==1) compares in_cnt against the live thr input.
    assign sum        = (first_beat ? '0 : acc) + ACC_W'(in_cnt);
    assign cmp_thr    = first_beat ? thr : thr_q;
    assign neuron_bit = binarize(sum, cmp_thr);

    // A pending flush acts only between neurons and never in the same cycle
    // as a completing beat, so it cannot race the shift register update.
    assign flush_idle = flush_pend & first_beat & ~neuron_done;
    assign flush_emit = flush_idle & (bit_idx != '0) & in_ready;
    assign flush_drop = flush_idle & (bit_idx == '0);

    always_comb begin
        shift_ins          = shift;
        shift_ins[bit_idx] = neuron_bit;
    end

    // Threshold is data only; it is always rewritten on a neuron's first beat.
    always_ff @(posedge clk) begin
        if (beat_hs && first_beat) begin
            thr_q <= thr;
        end
    end

    // Stage 1: accumulator, packer and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            chunk_idx  <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbits  <= '0;
        end else begin
            if (beat_hs) begin
                acc       <= sum;
                chunk_idx <= last_beat ? '0 : chunk_idx + 1'b1;
            end

            if (neuron_done) begin
                if (word_full) begin
                    shift   <= '0;
                    bit_idx <= '0;
                end else begin
                    shift   <= shift_ins;
                    bit_idx <= bit_idx + 1'b1;
                end
            end else if (flush_emit) begin
                shift   <= '0;
                bit_idx <= '0;
            end

            // A load always wins over a drain: in_ready guarantees the slot
            // is empty or being consumed whenever a new word is produced.
            if (word_full) begin
                out_valid <= 1'b1;
                out_data  <= shift_ins;
                out_nbits <= NB_W'(PACK_W);
            end else if (flush_emit) begin
                out_valid <= 1'b1;
                out_data  <= shift;
                out_nbits <= NB_W'(bit_idx);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            flush_pend <= (flush_pend & ~(flush_emit | flush_drop)) | flush;
        end
    end

endmodule

// File: tb/tb_popcount_binarize_pack.sv
// Testbench for popcount_binarize_pack with CNT_W=9, CHUNKS=4, PACK_W=8.
// Table-driven neuron vectors plus hand-written reset, backpressure and
// flush sequences. Inputs change on the falling edge; outputs are sampled
// on the falling edge or 3 ns after it, well before the next rising edge.
module tb_popcount_binarize_pack;

    localparam int CNT_W  = 9;
    localparam int CHUNKS = 4;
    localparam int PACK_W = 8;
    localparam int ACC_W  = 11;
    localparam int NB_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CNT_W-1:0]  in_cnt;
    logic [ACC_W-1:0]  thr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PACK_W-1:0] out_data;
    logic [NB_W-1:0]   out_nbits;

    popcount_binarize_pack #(
        .CNT_W  (CNT_W),
        .CHUNKS (CHUNKS),
        .PACK_W (PACK_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .thr       (thr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nbits (out_nbits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PACK_W-1:0] got_d[$];
    logic [NB_W-1:0]   got_n[$];

    typedef struct {
        int   c0;
        int   c1;
        int   c2;
        int   c3;
        int   t;
        logic expb;
    } nvec_t;

    nvec_t tab[16];
    nvec_t one_n;
    nvec_t zero_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Word collector and hold-stability check while the output is stalled.
    logic              prev_stall = 1'b0;
    logic [PACK_W-1:0] prev_data;
    logic [NB_W-1:0]   prev_nb;
    always @(negedge clk) begin
        #3;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_nbits", 32'(out_nbits), 32'(prev_nb));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_d.push_back(out_data);
            got_n.push_back(out_nbits);
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
        prev_data  = out_data;
        prev_nb    = out_nbits;
    end

    // One beat; called on a falling edge, returns on the falling edge after
    // the rising edge that accepted it. flush is held for one cycle only.
    task automatic beat(input logic [CNT_W-1:0] c, input logic [ACC_W-1:0] t, input logic f);
        bit done;
        int n;
        done     = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_cnt   = c;
        thr      = t;
        flush    = f;
        while (!done && n < 200) begin
            #3;
            if (in_ready === 1'b1) done = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=stalled required=accepted");
        end
    endtask

    // Later beats carry a scrambled thr; only the first-beat value may count.
    task automatic send_neuron(input nvec_t v, input int fb);
        int cs[4];
        cs = '{v.c0, v.c1, v.c2, v.c3};
        for (int k = 0; k < CHUNKS; k++) begin
            beat(CNT_W'(cs[k]), (k == 0) ? ACC_W'(v.t) : (ACC_W'(v.t) ^ 11'h7FF), (k == fb));
        end
    endtask

    task automatic run_table_word(input int base);
        logic [PACK_W-1:0] ew;
        ew = '0;
        for (int j = 0; j < PACK_W; j++) begin
            send_neuron(tab[base + j], -1);
            ew[j] = tab[base + j].expb;
        end
        chk($sformatf("word%0d_valid", base / PACK_W), 32'(out_valid), 32'd1);
        chk($sformatf("word%0d_data", base / PACK_W), 32'(out_data), 32'(ew));
        chk($sformatf("word%0d_nbits", base / PACK_W), 32'(out_nbits), 32'd8);
    endtask

    task automatic chk_q(input int idx, input logic [31:0] ed, input logic [31:0] en);
        logic [31:0] ad;
        logic [31:0] an;
        ad = (idx < got_d.size()) ? 32'(got_d[idx]) : 'x;
        an = (idx < got_n.size()) ? 32'(got_n[idx]) : 'x;
        chk($sformatf("q%0d_data", idx), ad, ed);
        chk($sformatf("q%0d_nbits", idx), an, en);
    endtask

    task automatic clear_q();
        got_d.delete();
        got_n.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        one_n  = '{64, 64, 64, 64, 256, 1'b1};
        zero_n = '{0, 0, 0, 255, 256, 1'b0};
        for (int i = 0; i < 8; i++) tab[i] = (i % 2 == 0) ? one_n : zero_n;
        tab[8]  = '{64, 64, 64, 63, 256, 1'b0};
        tab[9]  = '{64, 64, 64, 64, 256, 1'b1};
        tab[10] = '{256, 256, 256, 256, 1024, 1'b1};
        tab[11] = '{0, 0, 0, 0, 0, 1'b1};
        tab[12] = '{0, 0, 0, 0, 1, 1'b0};
        tab[13] = '{511, 511, 511, 511, 2047, 1'b0};
        tab[14] = '{511, 511, 511, 511, 2044, 1'b1};
        tab[15] = '{1, 0, 0, 0, 1, 1'b1};

        // Reset held 3 cycles with in_valid asserted
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_cnt    = 9'd64;
        thr       = 11'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_nbits", 32'(out_nbits), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_word", 32'(got_d.size()), 32'd0);

        // Alternating word 8'h55 and boundary-compare word
        clear_q();
        run_table_word(0);
        run_table_word(8);
        repeat (3) @(negedge clk);
        chk("tab_q_size", 32'(got_d.size()), 32'd2);
        chk_q(0, 32'h55, 32'd8);
        chk_q(1, 32'hCE, 32'd8);

        // Backpressure: word 1 held while word 2 stalls, then both in order
        clear_q();
        out_ready = 1'b0;
        for (int j = 0; j < 8; j++) send_neuron(one_n, -1);
        fork
            begin
                for (int j = 0; j < 8; j++) send_neuron((j < 4) ? one_n : zero_n, -1);
            end
            begin
                repeat (10) @(negedge clk);
                #3;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_out_data", 32'(out_data), 32'hFF);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk("bp_q_size", 32'(got_d.size()), 32'd2);
        chk_q(0, 32'hFF, 32'd8);
        chk_q(1, 32'h0F, 32'd8);

        // Flush mid-neuron 4, then a flush with nothing buffered
        clear_q();
        send_neuron(one_n, -1);
        send_neuron(one_n, -1);
        send_neuron(zero_n, -1);
        send_neuron(one_n, 1);
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 5) begin
                @(negedge clk);
                n++;
            end
        end
        chk("fl_out_valid", 32'(out_valid), 32'd1);
        chk("fl_out_data", 32'(out_data), 32'h0B);
        chk("fl_out_nbits", 32'(out_nbits), 32'd4);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("fl2_out_valid", 32'(out_valid), 32'd0);
        chk("fl_q_size", 32'(got_d.size()), 32'd1);
        chk_q(0, 32'h0B, 32'd4);

        // Reset mid-word discards stale bits and a half-summed neuron
        clear_q();
        for (int j = 0; j < 5; j++) send_neuron(zero_n, -1);
        beat(9'd255, 11'd256, 1'b0);
        beat(9'd255, 11'd256, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        for (int j = 0; j < 8; j++) send_neuron(one_n, -1);
        repeat (3) @(negedge clk);
        chk("mid_rst_q_size", 32'(got_d.size()), 32'd1);
        chk_q(0, 32'hFF, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
